pipe_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage RV32I pipe (fe,de,ex,mem,wb). Decides per cycle

---
 rtl/pipe_ctrl_if.sv | 39 +++
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller signal bundle between the 5-stage pipe datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       de_rs1;
  logic [4:0]       de_rs2;
  logic             de_rs1_used;
  logic             de_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic [4:0]       mem_rd;
  logic             redirect_valid;
  logic             mem_req;
  logic             mem_ready;
  logic             stall_fe;
  logic             stall_de;
  logic             stall_ex;
  logic             ex_bubble;
  logic             wb_bubble;
  logic             de_kill;
  logic [1:0]       fwd_rs1_sel;
  logic [1:0]       fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output de_rs1, de_rs2, de_rs1_used, de_rs2_used, ex_rd, ex_is_load, mem_rd,
           redirect_valid, mem_req, mem_ready,
    input  stall_fe, stall_de, stall_ex, ex_bubble, wb_bubble, de_kill,
           fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  de_rs1, de_rs2, de_rs1_used, de_rs2_used, ex_rd, ex_is_load, mem_rd,
           redirect_valid, mem_req, mem_ready,
    output stall_fe, stall_de, stall_ex, ex_bubble, wb_bubble, de_kill,
           fwd_rs1_sel, fwd_rs2_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipe: stalls, kills, bubbles and bypass selects.
// Optional perf counters (stall_cnt/flush_cnt) are built only with PIPE_CTRL_PERF_EN defined.
module pipe_ctrl #(
  parameter int unsigned REDIRECT_PENALTY = 2,
  parameter int unsigned CNT_W            = 16
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LD_STALL, FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0] PEN_INIT = 3'(REDIRECT_PENALTY - 1);
  localparam state_t     KILL_NX  = (REDIRECT_PENALTY > 1) ? FLUSH : RUN;

  state_t     state, state_nx;
  logic [2:0] pen_cnt, pen_cnt_nx;
  logic       pend, pend_nx;
  logic       mem_wait, load_use, redirect_go;
  logic       stall_fe_c, stall_de_c, stall_ex_c, ex_bubble_c, wb_bubble_c, de_kill_c;
  logic [1:0] sel1, sel2;

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input logic [4:0] ex_rd, input logic [4:0] mem_rd);
    if (used && rs != 5'd0 && rs == ex_rd)       return 2'd1;
    else if (used && rs != 5'd0 && rs == mem_rd) return 2'd2;
    else                                         return 2'd0;
  endfunction

  assign mem_wait = bus.mem_req & ~bus.mem_ready;
  assign load_use = bus.ex_is_load & (bus.ex_rd != 5'd0) &
                    ((bus.de_rs1_used & (bus.de_rs1 == bus.ex_rd)) |
                     (bus.de_rs2_used & (bus.de_rs2 == bus.ex_rd)));
  // A redirect parked during a memory wait is replayed on the cycle the wait ends.
  assign redirect_go = ~mem_wait & (bus.redirect_valid | ((state == MEM_WAIT) & pend));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pen_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      state   <= state_nx;
      pen_cnt <= pen_cnt_nx;
      pend    <= pend_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    pen_cnt_nx = pen_cnt;
    pend_nx    = pend;
    if (mem_wait) begin
      state_nx = MEM_WAIT;
      if (bus.redirect_valid) pend_nx = 1'b1;
    end else if (redirect_go) begin
      state_nx   = KILL_NX;
      pen_cnt_nx = PEN_INIT;
      pend_nx    = 1'b0;
    end else begin
      case (state)
        FLUSH: begin
          if (pen_cnt <= 3'd1) begin
            state_nx   = RUN;
            pen_cnt_nx = '0;
          end else begin
            pen_cnt_nx = pen_cnt - 3'd1;
          end
        end
        RUN:     state_nx = load_use ? LD_STALL : RUN;
        default: state_nx = RUN;
      endcase
    end
  end

  always_comb begin
    stall_fe_c  = 1'b0;
    stall_de_c  = 1'b0;
    stall_ex_c  = 1'b0;
    ex_bubble_c = 1'b0;
    wb_bubble_c = 1'b0;
    de_kill_c   = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        stall_fe_c  = 1'b1;
        stall_de_c  = 1'b1;
        stall_ex_c  = 1'b1;
        wb_bubble_c = 1'b1;
      end else if (redirect_go || state == FLUSH) begin
        de_kill_c = 1'b1;
      end else if (state == RUN && load_use) begin
        stall_fe_c  = 1'b1;
        stall_de_c  = 1'b1;
        ex_bubble_c = 1'b1;
      end
    end
  end

  // Selects follow the insn into exec; a load-use edge recomputes so the load is seen in mem next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel1 <= '0;
      sel2 <= '0;
    end else if (!stall_ex_c) begin
      if (de_kill_c) begin
        sel1 <= '0;
        sel2 <= '0;
      end else begin
        sel1 <= fwd_sel(bus.de_rs1_used, bus.de_rs1, bus.ex_rd, bus.mem_rd);
        sel2 <= fwd_sel(bus.de_rs2_used, bus.de_rs2, bus.ex_rd, bus.mem_rd);
      end
    end
  end

  assign bus.stall_fe    = stall_fe_c;
  assign bus.stall_de    = stall_de_c;
  assign bus.stall_ex    = stall_ex_c;
  assign bus.ex_bubble   = ex_bubble_c;
  assign bus.wb_bubble   = wb_bubble_c;
  assign bus.de_kill     = de_kill_c;
  assign bus.fwd_rs1_sel = sel1;
  assign bus.fwd_rs2_sel = sel2;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_fe_c && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (redirect_go && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed table-driven bench for pipe_ctrl plus hand sequences for reset and single-cycle penalty.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(16)) bus0 ();
  pipe_ctrl_if #(.CNT_W(16)) bus1 ();

  pipe_ctrl #(.REDIRECT_PENALTY(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus0));
  pipe_ctrl #(.REDIRECT_PENALTY(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       ld;
    logic [4:0] memrd;
    logic       redir, req, rdy;
    logic [5:0] ctrl;   // {stall_fe, stall_de, stall_ex, ex_bubble, wb_bubble, de_kill}
    logic [1:0] s1, s2;
    logic       chk_sel;
  } vec_t;

  vec_t tbl[25];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] exrd, input logic ld,
                              input logic [4:0] memrd, input logic redir, input logic req,
                              input logic rdy, input logic [5:0] ctrl, input logic [1:0] s1,
                              input logic [1:0] s2, input logic chk_sel);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exrd = exrd; v.ld = ld;
    v.memrd = memrd; v.redir = redir; v.req = req; v.rdy = rdy;
    v.ctrl = ctrl; v.s1 = s1; v.s2 = s2; v.chk_sel = chk_sel;
    return v;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus0.de_rs1 = v.rs1; bus0.de_rs2 = v.rs2;
    bus0.de_rs1_used = v.u1; bus0.de_rs2_used = v.u2;
    bus0.ex_rd = v.exrd; bus0.ex_is_load = v.ld; bus0.mem_rd = v.memrd;
    bus0.redirect_valid = v.redir; bus0.mem_req = v.req; bus0.mem_ready = v.rdy;
  endtask

  function automatic logic [5:0] ctrl0();
    return {bus0.stall_fe, bus0.stall_de, bus0.stall_ex, bus0.ex_bubble, bus0.wb_bubble, bus0.de_kill};
  endfunction

  initial begin
    // Each row is one cycle; selects show what the previous edge latched.
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[1]  = mk(5, 1, 1, 1, 5, 1, 0, 0, 0, 0, 6'b110100, 0, 0, 1);
    tbl[2]  = mk(5, 1, 1, 1, 0, 0, 5, 0, 0, 0, 6'b000000, 0, 0, 0);
    tbl[3]  = mk(5, 5, 1, 1, 5, 0, 0, 0, 0, 0, 6'b000000, 2, 0, 1);
    tbl[4]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 6'b000000, 1, 1, 1);
    tbl[5]  = mk(3, 0, 1, 1, 0, 0, 3, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[6]  = mk(4, 9, 0, 1, 4, 1, 0, 0, 0, 0, 6'b000000, 2, 0, 1);
    tbl[7]  = mk(6, 2, 1, 1, 6, 0, 6, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[8]  = mk(1, 8, 1, 1, 8, 1, 1, 0, 0, 0, 6'b110100, 1, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 8, 1, 0, 0, 6'b000001, 0, 0, 0);
    tbl[10] = mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[12] = mk(5, 0, 1, 0, 5, 1, 0, 1, 0, 0, 6'b000001, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000001, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 1);
    tbl[15] = mk(2, 0, 1, 0, 2, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 6'b111010, 1, 0, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111010, 1, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b111010, 1, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000001, 1, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 1);
    tbl[22] = mk(5, 0, 1, 0, 5, 1, 0, 0, 1, 0, 6'b111010, 0, 0, 1);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000000, 0, 0, 1);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000000, 0, 0, 1);

    drive(tbl[0]);
    bus1.de_rs1 = '0; bus1.de_rs2 = '0; bus1.de_rs1_used = 1'b0; bus1.de_rs2_used = 1'b0;
    bus1.ex_rd = '0; bus1.ex_is_load = 1'b0; bus1.mem_rd = '0;
    bus1.redirect_valid = 1'b0; bus1.mem_req = 1'b0; bus1.mem_ready = 1'b0;

    #2;
    check("reset_ctrl", ctrl0(), 0);
    check("reset_sel", {bus0.fwd_rs1_sel, bus0.fwd_rs2_sel}, 0);
    check("reset_cnt", {bus0.stall_cnt, bus0.flush_cnt}, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("row%0d_ctrl", i), ctrl0(), tbl[i].ctrl);
      if (tbl[i].chk_sel)
        check($sformatf("row%0d_sel", i), {bus0.fwd_rs1_sel, bus0.fwd_rs2_sel}, {tbl[i].s1, tbl[i].s2});
    end

`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt", bus0.stall_cnt, 6);
    check("flush_cnt", bus0.flush_cnt, 4);
`else
    check("stall_cnt_tied", bus0.stall_cnt, 0);
    check("flush_cnt_tied", bus0.flush_cnt, 0);
`endif

    // Reset during a load-use stall: outputs drop at once, no residual stall after release.
    @(negedge clk);
    drive(mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0));
    @(negedge clk);
    drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 6'b0, 0, 0, 0));
    #1;
    check("pre_rst_stall", ctrl0(), 6'b110100);
    check("pre_rst_sel", bus0.fwd_rs1_sel, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", ctrl0(), 0);
    check("mid_rst_sel", {bus0.fwd_rs1_sel, bus0.fwd_rs2_sel}, 0);
    check("mid_rst_cnt", {bus0.stall_cnt, bus0.flush_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(tbl[0]);
    #1;
    check("post_rst_idle", ctrl0(), 0);
    @(negedge clk);
    drive(mk(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 6'b0, 0, 0, 0));
    #1;
    check("post_rst_ld_stall", ctrl0(), 6'b110100);
    @(negedge clk);
    drive(mk(5, 0, 1, 0, 0, 0, 5, 0, 0, 0, 6'b0, 0, 0, 0));
    #1;
    check("post_rst_ld_release", ctrl0(), 0);

    // Single-cycle penalty: kill only in the redirect cycle.
    @(negedge clk);
    bus1.redirect_valid = 1'b1;
    #1;
    check("pen1_kill", bus1.de_kill, 1);
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    #1;
    check("pen1_after", bus1.de_kill, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
